// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Brief    : Carry-chunked pipelined adder/subtractor with global stall and
//            valid/ready handshakes. Optional signed saturation via the
//            PIPE_ADDER_SAT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_adder #(
    parameter int DataWidth = 32,
    parameter int Stages    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    input  logic                 sub_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] y_o,
    output logic                 carry_o,
    output logic                 ovf_o
);

    localparam int c_chunk_w = (Stages > 0) ? DataWidth / Stages : DataWidth;

    if (Stages < 1) begin : g_bad_stages
        $error("pipe_adder: Stages must be at least 1");
    end else if (DataWidth % Stages != 0) begin : g_bad_width
        $error("pipe_adder: DataWidth must be a multiple of Stages");
    end

    // Per-stage skew registers: operands, partial result, chunk carry, valid
    logic [DataWidth-1:0] r_a [Stages];
    logic [DataWidth-1:0] r_b [Stages];
    logic [DataWidth-1:0] r_y [Stages];
    logic                 r_c [Stages];
    logic                 r_v [Stages];
    logic                 r_ovf;

    logic [DataWidth-1:0] w_ain  [Stages];
    logic [DataWidth-1:0] w_bin  [Stages];
    logic [DataWidth-1:0] w_yin  [Stages];
    logic                 w_cin  [Stages];
    logic [c_chunk_w:0]   w_sum  [Stages];
    logic [DataWidth-1:0] w_y    [Stages];
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic                 w_ovf;
    logic [DataWidth-1:0] w_yout;
    logic                 w_en;

    assign valid_o = r_v[Stages-1];
    assign y_o     = r_y[Stages-1];
    assign carry_o = r_c[Stages-1];
    assign ovf_o   = r_ovf;

    // One stall signal for the whole pipeline
    assign w_en    = !valid_o || ready_i;
    assign ready_o = w_en;

    always_comb begin
        // Stage 0 sees the raw operands; subtract folds in as ~B with carry-in 1
        w_ain[0] = a_i;
        w_bin[0] = sub_i ? ~b_i : b_i;
        w_cin[0] = sub_i;
        w_yin[0] = '0;
        for (int k = 1; k < Stages; k++) begin
            w_ain[k] = r_a[k-1];
            w_bin[k] = r_b[k-1];
            w_cin[k] = r_c[k-1];
            w_yin[k] = r_y[k-1];
        end
        for (int k = 0; k < Stages; k++) begin
            w_sum[k] = {1'b0, w_ain[k][k*c_chunk_w +: c_chunk_w]}
                     + {1'b0, w_bin[k][k*c_chunk_w +: c_chunk_w]}
                     + {{c_chunk_w{1'b0}}, w_cin[k]};
            w_y[k]   = w_yin[k];
            w_y[k][k*c_chunk_w +: c_chunk_w] = w_sum[k][c_chunk_w-1:0];
        end
    end

    assign w_sign_a = w_ain[Stages-1][DataWidth-1];
    assign w_sign_b = w_bin[Stages-1][DataWidth-1];
    assign w_ovf    = (w_sign_a == w_sign_b) && (w_y[Stages-1][DataWidth-1] != w_sign_a);

`ifdef PIPE_ADDER_SAT_EN
    // Clamp toward the sign of A; carry and overflow flags stay unsaturated
    assign w_yout = !w_ovf ? w_y[Stages-1] :
                    w_sign_a ? {1'b1, {(DataWidth-1){1'b0}}}
                             : {1'b0, {(DataWidth-1){1'b1}}};
`else
    assign w_yout = w_y[Stages-1];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < Stages; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_y[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_v[0] <= valid_i;
            for (int k = 1; k < Stages; k++) begin
                r_v[k] <= r_v[k-1];
            end
            for (int k = 0; k < Stages; k++) begin
                r_a[k] <= w_ain[k];
                r_b[k] <= w_bin[k];
                r_c[k] <= w_sum[k][c_chunk_w];
                r_y[k] <= (k == Stages - 1) ? w_yout : w_y[k];
            end
            r_ovf <= w_ovf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// Testbench for pipe_adder: directed corner cases, back-pressure, throughput,
// mid-flight reset and a randomized sweep over several configurations.
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid_i, sub, ready_i;
    logic [31:0] a, b;
    logic        ready_o, valid_o, carry, ovf;
    logic [31:0] y;

    pipe_adder #(.DataWidth(32), .Stages(4)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a), .b_i(b), .sub_i(sub), .valid_o(valid_o), .ready_i(ready_i),
        .y_o(y), .carry_o(carry), .ovf_o(ovf)
    );

    // Sweep instances share one stimulus stream and always accept output
    logic        sw_valid, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic        sw_v [4];
    logic        sw_c [4];
    logic        sw_o [4];
    logic        sw_r [4];
    logic [63:0] sw_y [4];
    logic [31:0] y_s1, y_s2, y_s8;
    logic [63:0] y_w64;

    pipe_adder #(.DataWidth(32), .Stages(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .valid_i(sw_valid), .ready_o(sw_r[0]),
        .a_i(sw_a[31:0]), .b_i(sw_b[31:0]), .sub_i(sw_sub), .valid_o(sw_v[0]),
        .ready_i(1'b1), .y_o(y_s1), .carry_o(sw_c[0]), .ovf_o(sw_o[0]));
    pipe_adder #(.DataWidth(32), .Stages(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .valid_i(sw_valid), .ready_o(sw_r[1]),
        .a_i(sw_a[31:0]), .b_i(sw_b[31:0]), .sub_i(sw_sub), .valid_o(sw_v[1]),
        .ready_i(1'b1), .y_o(y_s2), .carry_o(sw_c[1]), .ovf_o(sw_o[1]));
    pipe_adder #(.DataWidth(32), .Stages(8)) u_s8 (
        .clk_i(clk), .rst_i(rst), .valid_i(sw_valid), .ready_o(sw_r[2]),
        .a_i(sw_a[31:0]), .b_i(sw_b[31:0]), .sub_i(sw_sub), .valid_o(sw_v[2]),
        .ready_i(1'b1), .y_o(y_s8), .carry_o(sw_c[2]), .ovf_o(sw_o[2]));
    pipe_adder #(.DataWidth(64), .Stages(4)) u_w64 (
        .clk_i(clk), .rst_i(rst), .valid_i(sw_valid), .ready_o(sw_r[3]),
        .a_i(sw_a), .b_i(sw_b), .sub_i(sw_sub), .valid_o(sw_v[3]),
        .ready_i(1'b1), .y_o(y_w64), .carry_o(sw_c[3]), .ovf_o(sw_o[3]));

    assign sw_y[0] = {32'b0, y_s1};
    assign sw_y[1] = {32'b0, y_s2};
    assign sw_y[2] = {32'b0, y_s8};
    assign sw_y[3] = y_w64;

    int errors = 0;
    int checks = 0;

    // Reference: plain w-bit arithmetic; returns {ovf, carry, y}
    function automatic logic [65:0] model(input int w, input logic [63:0] x1,
                                          input logic [63:0] x2, input logic s);
        logic [63:0] mask, bx, r;
        logic [64:0] sum;
        logic        sa, sb, cr, o;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        bx   = (s ? ~x2 : x2) & mask;
        sum  = {1'b0, x1 & mask} + {1'b0, bx} + {64'd0, s};
        cr   = sum[w];
        r    = sum[63:0] & mask;
        sa   = x1[w-1];
        sb   = bx[w-1];
        o    = (sa == sb) && (r[w-1] != sa);
`ifdef PIPE_ADDER_SAT_EN
        if (o) r = sa ? (64'd1 << (w - 1)) : (mask >> 1);
`endif
        return {o, cr, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one beat into an empty pipeline and report the result and latency
    task automatic run_one(input logic [31:0] x1, input logic [31:0] x2, input logic s,
                           output logic [31:0] ry, output logic rc, output logic ro,
                           output int lat);
        a = x1; b = x2; sub = s; valid_i = 1'b1; ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 20) begin
            step();
            lat++;
        end
        if (!valid_o) lat = -1;
        ry = y; rc = carry; ro = ovf;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; a = 32'h1234_5678; b = 32'h1; sub = 1'b0; ready_i = 1'b1;
        step();
        step();
        rst = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o);
        if (valid_o !== 1'b0) errors++;
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y: got %h expected 0", y); end
        checks++; if (carry !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got c=%b o=%b expected 0 0", carry, ovf);
        end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (valid_o !== 1'b0) begin
                errors++; $display("FAIL reset_input_ignored: cycle %0d valid_o=%b expected 0", i, valid_o);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ry; logic rc, ro; int lat;
        run_one(32'hFFFF_FFFF, 32'h1, 1'b0, ry, rc, ro, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL wrap_latency: got %0d expected 4", lat); end
        checks++; if ({ro, rc, ry} !== {1'b0, 1'b1, 32'h0}) begin
            errors++; $display("FAIL wrap_result: got o=%b c=%b y=%h expected o=0 c=1 y=00000000", ro, rc, ry);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ry, ey; logic rc, ro; int lat;
`ifdef PIPE_ADDER_SAT_EN
        ey = 32'h7FFF_FFFF;
`else
        ey = 32'h8000_0000;
`endif
        run_one(32'h7FFF_FFFF, 32'h1, 1'b0, ry, rc, ro, lat);
        checks++; if ({lat == 4, ro, rc, ry} !== {1'b1, 1'b1, 1'b0, ey}) begin
            errors++; $display("FAIL ovf_pos: got lat=%0d o=%b c=%b y=%h expected lat=4 o=1 c=0 y=%h", lat, ro, rc, ry, ey);
        end
        run_one(32'h0, 32'h1, 1'b1, ry, rc, ro, lat);
        checks++; if ({lat == 4, ro, rc, ry} !== {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL sub_borrow: got lat=%0d o=%b c=%b y=%h expected lat=4 o=0 c=0 y=ffffffff", lat, ro, rc, ry);
        end
`ifdef PIPE_ADDER_SAT_EN
        ey = 32'h8000_0000;
`else
        ey = 32'h7FFF_FFFF;
`endif
        run_one(32'h8000_0000, 32'h1, 1'b1, ry, rc, ro, lat);
        checks++; if ({lat == 4, ro, rc, ry} !== {1'b1, 1'b1, 1'b1, ey}) begin
            errors++; $display("FAIL ovf_neg: got lat=%0d o=%b c=%b y=%h expected lat=4 o=1 c=1 y=%h", lat, ro, rc, ry, ey);
        end
    endtask

    task automatic test_back_pressure();
        int sent = 0, got = 0;
        logic [31:0] held = '0;
        logic was_stall = 1'b0, in_x;
        logic [65:0] e;
        for (int c = 0; c < 60 && got < 8; c++) begin
            ready_i = !(c >= 5 && c <= 9);
            valid_i = (sent < 8);
            a = 32'(sent); b = 32'h100; sub = 1'b0;
            #1;
            if (was_stall) begin
                checks++;
                if (y !== held) begin errors++; $display("FAIL bp_hold: cycle %0d y=%h expected %h", c, y, held); end
            end
            was_stall = valid_o && !ready_i;
            held = y;
            if (was_stall) begin
                checks++;
                if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: cycle %0d ready_o=%b expected 0", c, ready_o); end
            end
            if (valid_o && ready_i) begin
                e = model(32, 64'(got), 64'h100, 1'b0);
                checks++;
                if (y !== e[31:0]) begin errors++; $display("FAIL bp_data: beat %0d y=%h expected %h", got, y, e[31:0]); end
                got++;
            end
            in_x = valid_i && ready_o;
            step();
            if (in_x) sent++;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        checks++; if (got != 8) begin errors++; $display("FAIL bp_count: got %0d results expected 8", got); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_extra: valid_o=%b expected 0 after drain", valid_o); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [16];
        logic [31:0] tb2 [16];
        logic        ts [16];
        logic [65:0] e;
        int j;
        logic ev;
        ready_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                ta[c] = $urandom; tb2[c] = $urandom; ts[c] = 1'($urandom_range(0, 1));
                valid_i = 1'b1; a = ta[c]; b = tb2[c]; sub = ts[c];
            end else begin
                valid_i = 1'b0;
            end
            step();
            j  = c + 1 - 4;
            ev = (j >= 0 && j < 16);
            checks++;
            if (valid_o !== ev) begin errors++; $display("FAIL b2b_valid: cycle %0d valid_o=%b expected %b", c + 1, valid_o, ev); end
            if (ev && valid_o) begin
                e = model(32, {32'b0, ta[j]}, {32'b0, tb2[j]}, ts[j]);
                checks++;
                if ({ovf, carry, y} !== {e[65:64], e[31:0]}) begin
                    errors++; $display("FAIL b2b_data: beat %0d got o=%b c=%b y=%h expected o=%b c=%b y=%h",
                                       j, ovf, carry, y, e[65], e[64], e[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; a = 32'h1111_1111 * 32'(i + 1); b = 32'h0F0F_0F0F; sub = 1'b0;
            step();
        end
        valid_i = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({valid_o, carry, ovf, y} !== 35'h0) begin
            errors++; $display("FAIL midrst_outputs: got v=%b c=%b o=%b y=%h expected all 0", valid_o, carry, ovf, y);
        end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready_o); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_ghost: cycle %0d valid_o=%b expected 0", i, valid_o); end
        end
    endtask

    task automatic test_param_sweep();
        int          wid [4] = '{32, 32, 32, 64};
        int          stg [4] = '{1, 2, 8, 4};
        logic [63:0] ha [2048];
        logic [63:0] hb [2048];
        logic        hs [2048];
        logic        hv [2048];
        logic [65:0] e;
        int sent = 0, drain = 0, j;
        logic ev;
        rst = 1'b1; sw_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (sent < 1000 && $urandom_range(0, 9) != 0) begin
                hv[c] = 1'b1; ha[c] = {$urandom, $urandom}; hb[c] = {$urandom, $urandom};
                hs[c] = 1'($urandom_range(0, 1));
                sent++;
            end else begin
                hv[c] = 1'b0; ha[c] = '0; hb[c] = '0; hs[c] = 1'b0;
            end
            sw_valid = hv[c]; sw_a = ha[c]; sw_b = hb[c]; sw_sub = hs[c];
            step();
            for (int i = 0; i < 4; i++) begin
                j  = c + 1 - stg[i];
                ev = (j >= 0) ? hv[j] : 1'b0;
                checks++;
                if (sw_v[i] !== ev) begin
                    errors++; $display("FAIL sweep_valid: W=%0d S=%0d cycle %0d valid_o=%b expected %b", wid[i], stg[i], c + 1, sw_v[i], ev);
                end
                if (ev && sw_v[i]) begin
                    e = model(wid[i], ha[j], hb[j], hs[j]);
                    checks++;
                    if ({sw_o[i], sw_c[i], sw_y[i]} !== e) begin
                        errors++; $display("FAIL sweep_data: W=%0d S=%0d beat@%0d got %h expected %h", wid[i], stg[i], j, {sw_o[i], sw_c[i], sw_y[i]}, e);
                    end
                end
            end
            if (sent == 1000) drain++;
            if (drain > 10) break;
        end
        sw_valid = 1'b0;
        checks++; if (sent != 1000) begin errors++; $display("FAIL sweep_budget: sent %0d beats expected 1000", sent); end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; sub = 1'b0; ready_i = 1'b1; a = '0; b = '0;
        sw_valid = 1'b0; sw_sub = 1'b0; sw_a = '0; sw_b = '0;
        test_reset();
        test_wrap();
        test_overflow();
        test_back_pressure();
        test_back_to_back();
        test_reset_midflight();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
